// File: rtl/fir_sched.sv
// Shared-MAC scheduler for a two-channel FIR: round-robin grant, CLR/RUN/DONE sequencing.
// Optional sticky overrun flags are built only when FIR_SCHED_OVERRUN_EN is defined.
module fir_sched #(
   parameter int TAPS     = 32,
   parameter int TAP_BITS = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample0,
   input  logic                sample1,
   input  logic                cfg_mode0,
   input  logic                cfg_mode1,
   output logic                grant_ch,
   output logic [TAP_BITS-1:0] tap,
   output logic [TAP_BITS-1:0] coef_addr,
   output logic                coef_mode,
   output logic                mac_clr,
   output logic                mac_en,
   output logic                out_valid,
   output logic                out_ch,
   output logic                busy,
   output logic [1:0]          overrun
);

   typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

   localparam logic [TAP_BITS-1:0] TAP_LAST = TAP_BITS'(TAPS - 1);

   state_t     state, state_nx;
   logic [1:0] pend, pend_nx;
   logic [1:0] samples;
   logic [1:0] clr_mask;
   logic       last_ch;
   logic       start;
   logic       gnt_nx;

   assign samples = {sample1, sample0};

   // Round-robin only matters when both are pending; otherwise the lone requester wins.
   assign gnt_nx   = (&pend) ? ~last_ch : pend[1];
   assign clr_mask = start ? (gnt_nx ? 2'b10 : 2'b01) : 2'b00;
   // A strobe on the granting edge re-arms the request (set wins over clear).
   assign pend_nx  = (pend & ~clr_mask) | samples;

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      case (state)
         IDLE: if (|pend) begin
            state_nx = CLR;
            start    = 1'b1;
         end
         CLR:  state_nx = RUN;
         RUN:  if (tap == TAP_LAST) state_nx = DONE;
         DONE: if (|pend) begin
            state_nx = CLR;
            start    = 1'b1;
         end else begin
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         pend      <= 2'b00;
         last_ch   <= 1'b1;
         grant_ch  <= 1'b0;
         coef_mode <= 1'b0;
         tap       <= '0;
      end else begin
         state <= state_nx;
         pend  <= pend_nx;
         if (start) begin
            grant_ch  <= gnt_nx;
            last_ch   <= gnt_nx;
            coef_mode <= gnt_nx ? cfg_mode1 : cfg_mode0;
         end
         // TAPS is a power of two, so the increment wraps to 0 on the last tap.
         if (state == RUN) tap <= tap + TAP_BITS'(1);
         else              tap <= '0;
      end
   end

`ifdef FIR_SCHED_OVERRUN_EN
   logic [1:0] ovr_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ovr_q <= 2'b00;
      else        ovr_q <= ovr_q | (samples & pend & ~clr_mask);
   end

   assign overrun = ovr_q;
`else
   assign overrun = 2'b00;
`endif

   assign coef_addr = ~tap + TAP_BITS'(1);
   assign mac_clr   = (state == CLR);
   assign mac_en    = (state == RUN);
   assign out_valid = (state == DONE);
   assign out_ch    = (state == DONE) & grant_ch;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fir_sched.sv
// Bench for fir_sched: directed scenarios plus random strobes against a phase-based model.
module tb_fir_sched;
   localparam int TAPS     = 32;
   localparam int TAP_BITS = 5;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                sample0 = 1'b0, sample1 = 1'b0;
   logic                cfg_mode0 = 1'b0, cfg_mode1 = 1'b0;
   logic                grant_ch, coef_mode, mac_clr, mac_en, out_valid, out_ch, busy;
   logic [TAP_BITS-1:0] tap, coef_addr;
   logic [1:0]          overrun;

   fir_sched #(.TAPS(TAPS), .TAP_BITS(TAP_BITS)) dut (
      .clk(clk), .reset(reset), .sample0(sample0), .sample1(sample1),
      .cfg_mode0(cfg_mode0), .cfg_mode1(cfg_mode1), .grant_ch(grant_ch), .tap(tap),
      .coef_addr(coef_addr), .coef_mode(coef_mode), .mac_clr(mac_clr), .mac_en(mac_en),
      .out_valid(out_valid), .out_ch(out_ch), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

`ifdef FIR_SCHED_OVERRUN_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Model: ph = -1 idle, 0 clear, 1..TAPS run (tap = ph-1), TAPS+1 done.
   int       ph;
   bit [1:0] m_pend, m_ovr;
   bit       m_last, m_gch, m_gmode;
   int       cyc, cnt_busy;
   int       cnt_res[2];
   int       res_cyc[$];
   bit       res_ch[$];

   task automatic model_reset();
      ph = -1; m_pend = 2'b00; m_ovr = 2'b00;
      m_last = 1'b1; m_gch = 1'b0; m_gmode = 1'b0;
   endtask

   task automatic model_edge();
      bit [1:0] s;
      bit       enter, g;
      s     = {sample1, sample0};
      enter = (ph == -1 || ph == TAPS + 1) && (m_pend != 2'b00);
      if (m_pend == 2'b11) g = ~m_last;
      else                 g = m_pend[1];
      if (OVR_EN) begin
         if (s[0] && m_pend[0] && !(enter && !g)) m_ovr[0] = 1'b1;
         if (s[1] && m_pend[1] && !(enter &&  g)) m_ovr[1] = 1'b1;
      end
      if (enter) begin
         m_last = g; m_gch = g;
         m_gmode = g ? cfg_mode1 : cfg_mode0;
         m_pend[g] = 1'b0;
      end
      m_pend = m_pend | s;
      if (enter)                ph = 0;
      else if (ph == TAPS + 1)  ph = -1;
      else if (ph >= 0)         ph++;
   endtask

   task automatic compare_all(input string tag);
      int           et;
      logic [18:0]  a, e;
      et = (ph >= 1 && ph <= TAPS) ? ph - 1 : 0;
      a = {grant_ch, tap, coef_addr, coef_mode, mac_clr, mac_en, out_valid, out_ch, busy, overrun};
      e = {m_gch, TAP_BITS'(et), TAP_BITS'((TAPS - et) % TAPS), m_gmode,
           ph == 0, ph >= 1 && ph <= TAPS, ph == TAPS + 1,
           ph == TAPS + 1 && m_gch, ph >= 0, m_ovr};
      chk(tag, 32'(a), 32'(e));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cyc++;
      compare_all("outs");
      if (busy) cnt_busy++;
      if (out_valid) begin
         cnt_res[out_ch]++;
         res_cyc.push_back(cyc);
         res_ch.push_back(out_ch);
      end
   endtask

   task automatic clear_stats();
      cnt_busy = 0; cnt_res[0] = 0; cnt_res[1] = 0;
      res_cyc.delete(); res_ch.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      sample0 = 1'b0; sample1 = 1'b0;
      #2 reset = 1'b0;
      model_reset();
      #1 compare_all("rst_async");
      @(negedge clk);
      reset = 1'b1;
      clear_stats();
   endtask

   task automatic pulse(input bit s0, input bit s1);
      sample0 = s0; sample1 = s1;
      step();
      sample0 = 1'b0; sample1 = 1'b0;
   endtask

   initial begin
      int k;
      cyc = 0;
      model_reset();
      clear_stats();
      #1 compare_all("rst_init");
      @(negedge clk);
      reset = 1'b1;

      // Single sample0 from idle: latency and busy length.
      pulse(1'b1, 1'b0);
      k = 1;
      while (!out_valid && k < 100) begin step(); k++; end
      chk("latency", 32'(k - 1), 32'(TAPS + 2));
      chk("res_ch0", 32'(out_ch), 32'd0);
      repeat (4) step();
      chk("busy_len", 32'(cnt_busy), 32'(TAPS + 2));

      // Simultaneous requests after reset: ch0 then ch1, back to back.
      do_reset();
      pulse(1'b1, 1'b1);
      repeat (2 * TAPS + 10) step();
      chk("rr_count", 32'(res_cyc.size()), 32'd2);
      if (res_cyc.size() == 2) begin
         chk("rr_first", 32'(res_ch[0]), 32'd0);
         chk("rr_second", 32'(res_ch[1]), 32'd1);
         chk("rr_gap", 32'(res_cyc[1] - res_cyc[0]), 32'(TAPS + 2));
      end

      // Repeated sample1 while pending and ch0 running.
      do_reset();
      pulse(1'b1, 1'b0);
      repeat (3) step();
      pulse(1'b0, 1'b1);
      repeat (5) step();
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      repeat (2 * TAPS + 10) step();
      chk("ovr_flags", 32'(overrun), OVR_EN ? 32'h2 : 32'h0);
      chk("ovr_ch1_res", 32'(cnt_res[1]), 32'd1);
      chk("ovr_ch0_res", 32'(cnt_res[0]), 32'd1);

      // sample0 on the very edge that grants channel 0.
      do_reset();
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      repeat (2 * TAPS + 10) step();
      chk("same_edge_res", 32'(cnt_res[0]), 32'd2);
      chk("same_edge_ovr", 32'(overrun), 32'd0);

      // Reset mid-RUN at tap 10, then channel 1 alone.
      do_reset();
      pulse(1'b1, 1'b0);
      k = 0;
      while (ph != 11 && k < 50) begin step(); k++; end
      chk("reach_tap10", 32'(tap), 32'd10);
      #2 reset = 1'b0;
      model_reset();
      #1 compare_all("rst_midrun");
      chk("rst_outs", 32'({mac_clr, mac_en, out_valid, out_ch, busy, grant_ch, tap}), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      clear_stats();
      pulse(1'b0, 1'b1);
      step();
      chk("post_rst_gnt", 32'(grant_ch), 32'd1);
      repeat (TAPS + 6) step();
      chk("post_rst_ch0", 32'(cnt_res[0]), 32'd0);
      chk("post_rst_ch1", 32'(cnt_res[1]), 32'd1);

      // cfg_mode1 changed mid-service only applies at the next grant.
      do_reset();
      cfg_mode1 = 1'b0;
      pulse(1'b0, 1'b1);
      repeat (6) step();
      cfg_mode1 = 1'b1;
      repeat (10) step();
      chk("mode_hold", 32'(coef_mode), 32'd0);
      repeat (TAPS) step();
      pulse(1'b0, 1'b1);
      repeat (3) step();
      chk("mode_new", 32'(coef_mode), 32'd1);

      // Random traffic.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 1999) == 0) do_reset();
         sample0 = ($urandom_range(0, 24) == 0);
         sample1 = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 15) == 0) cfg_mode0 = ~cfg_mode0;
         if ($urandom_range(0, 15) == 0) cfg_mode1 = ~cfg_mode1;
         step();
      end
      sample0 = 1'b0; sample1 = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
